// File: rtl/inc_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : inc_rr_scheduler
// Description : Shares one WIDTH-bit incrementer (a + 1, modulo 2^WIDTH)
//               among N_REQ requesters. A round-robin arbiter picks one
//               valid requester per cycle; its operand is incremented and
//               registered into a single-entry response slot tagged with
//               the requester ID.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   req_valid  in   N_REQ        per-requester operand valid
//   req_data   in   N_REQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  out  N_REQ        one-hot grant (combinational)
//   rsp_valid  out  1            response slot occupied
//   rsp_data   out  WIDTH        incremented operand
//   rsp_id     out  ID_W         requester that produced rsp_data
//   rsp_ovf    out  1            operand was all-ones, result wrapped to 0
//   rsp_ready  in   1            consumer accepts response
// ============================================================================
module inc_rr_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_ovf,
   input  logic                   rsp_ready
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FULL = 1'b1
   } state_t;

   localparam logic [ID_W:0]   c_n_req   = (ID_W+1)'(N_REQ);
   localparam logic [ID_W-1:0] c_last_id = ID_W'(N_REQ-1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [WIDTH-1:0]  r_rsp_data;
   logic [ID_W-1:0]   r_rsp_id;
   logic              r_rsp_ovf;

   logic [ID_W:0]     w_cand;
   logic              w_found;
   logic [ID_W-1:0]   w_gnt_id;
   logic              w_slot_free;
   logic              w_accept;
   logic [WIDTH-1:0]  w_operand;
   logic [ID_W-1:0]   w_ptr_nxt;

   // Round-robin search: walk the requesters starting at r_rr_ptr and
   // keep the first valid one. The candidate index is kept one bit wider
   // so the wrap past N_REQ-1 can be folded back with a single subtract.
   always_comb begin
      w_found  = 1'b0;
      w_gnt_id = '0;
      w_cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
         if (w_cand >= c_n_req) begin
            w_cand = w_cand - c_n_req;
         end
         if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
            w_found  = 1'b1;
            w_gnt_id = w_cand[ID_W-1:0];
         end
      end
   end

   assign rsp_valid   = (r_state == FULL);
   assign w_slot_free = !rsp_valid || rsp_ready;

   // Grant is held off while rst is high so nothing appears to handshake
   // on the edge that reset is discarding.
   always_comb begin
      req_ready = '0;
      if (!rst && w_found && w_slot_free) begin
         req_ready[w_gnt_id] = 1'b1;
      end
   end

   assign w_accept  = |(req_valid & req_ready);
   assign w_operand = req_data[w_gnt_id*WIDTH +: WIDTH];
   assign w_ptr_nxt = (w_gnt_id == c_last_id) ? '0 : w_gnt_id + 1'b1;

   // Next-state logic. FULL only drains to IDLE when the consumer takes
   // the response and nothing new is accepted in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = FULL;
            end
         end
         FULL: begin
            if (rsp_ready && !w_accept) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Response slot and pointer only move on an accepted request; a stall
   // leaves everything untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_data <= '0;
         r_rsp_id   <= '0;
         r_rsp_ovf  <= 1'b0;
         r_rr_ptr   <= '0;
      end else if (w_accept) begin
         r_rsp_data <= w_operand + 1'b1;
         r_rsp_id   <= w_gnt_id;
         r_rsp_ovf  <= &w_operand;
         r_rr_ptr   <= w_ptr_nxt;
      end
   end

   assign rsp_data = r_rsp_data;
   assign rsp_id   = r_rsp_id;
   assign rsp_ovf  = r_rsp_ovf;

endmodule
`default_nettype wire

// File: tb/tb_inc_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_inc_rr_scheduler
// Description : Self-checking bench for inc_rr_scheduler. Directed steps
//               followed by randomized traffic, compared against a
//               behavioural model of the arbiter and response slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inc_rr_scheduler;

   localparam int N = 4;
   localparam int W = 4;
   localparam int I = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [W-1:0]   rsp_data;
   logic [I-1:0]   rsp_id;
   logic           rsp_ovf;
   logic           rsp_ready;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_ptr;
   int m_valid;
   int m_data;
   int m_id;
   int m_ovf;
   int last_acc;
   int last_g;

   inc_rr_scheduler #(.N_REQ(N), .WIDTH(W), .ID_W(I)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ovf   (rsp_ovf),
      .rsp_ready (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_valid = 0;
      m_data  = 0;
      m_id    = 0;
      m_ovf   = 0;
   endtask

   // One clock cycle: apply inputs just after an edge, check the
   // combinational grant and the visible response, then advance the model
   // across the next rising edge.
   task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic rr);
      int           g;
      int           oper;
      logic         free;
      logic [N-1:0] exp_rdy;
      req_valid = v;
      req_data  = d;
      rsp_ready = rr;
      #1;
      free = (m_valid == 0) || rr;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_ptr + k) % N;
         if (g < 0 && v[c]) g = c;
      end
      exp_rdy = '0;
      if (free && g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid != 0) begin
         chk("rsp_data", rsp_data, m_data);
         chk("rsp_id", rsp_id, m_id);
         chk("rsp_ovf", rsp_ovf, m_ovf);
      end
      @(posedge clk);
      if (free && g >= 0) begin
         oper     = int'((d >> (g*W)) & ((1 << W) - 1));
         m_data   = (oper + 1) % (1 << W);
         m_ovf    = (oper == (1 << W) - 1) ? 1 : 0;
         m_id     = g;
         m_ptr    = (g + 1) % N;
         m_valid  = 1;
         last_acc = 1;
         last_g   = g;
      end else begin
         last_acc = 0;
         if (rr) m_valid = 0;
      end
      #1;
   endtask

   initial begin
      int           seq [6];
      logic [W-1:0] s_data;
      logic [I-1:0] s_id;
      logic         s_ovf;
      logic [N-1:0]   pv;
      logic [N*W-1:0] pd;
      logic           rr;

      seq = '{0, 1, 2, 3, 0, 1};
      last_acc = 0;
      last_g   = 0;
      model_reset();

      // Reset with all requesters valid
      rst       = 1'b1;
      req_valid = '1;
      req_data  = 16'h1234;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_data", rsp_data, 4'h0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_ovf", rsp_ovf, 1'b0);
      rst = 1'b0;
      cycle(4'b1111, 16'h1234, 1'b1);
      chk("first_grant_id", rsp_id, 2'd0);
      chk("first_grant_data", rsp_data, 4'h5);

      // Requester 1 alone, operand 0111
      cycle(4'b0010, 16'h0070, 1'b1);
      chk("r1_valid", rsp_valid, 1'b1);
      chk("r1_data", rsp_data, 4'b1000);
      chk("r1_id", rsp_id, 2'd1);
      chk("r1_ovf", rsp_ovf, 1'b0);

      // Requester 2 with all-ones operand wraps to zero
      cycle(4'b0100, 16'h0F00, 1'b1);
      chk("wrap_data", rsp_data, 4'b0000);
      chk("wrap_ovf", rsp_ovf, 1'b1);
      chk("wrap_id", rsp_id, 2'd2);

      // Single requester 3 moves the pointer back to 0
      cycle(4'b1000, 16'h9000, 1'b1);
      chk("r3_id", rsp_id, 2'd3);

      // All valid continuously: one response per cycle in rotation
      for (int k = 0; k < 6; k++) begin
         cycle(4'b1111, 16'h4321, 1'b1);
         chk("rr_valid", rsp_valid, 1'b1);
         chk("rr_seq_id", rsp_id, seq[k]);
      end

      // Stall for three cycles while FULL
      s_data = rsp_data;
      s_id   = rsp_id;
      s_ovf  = rsp_ovf;
      for (int k = 0; k < 3; k++) begin
         cycle(4'b1111, 16'h4321, 1'b0);
         chk("stall_data", rsp_data, s_data);
         chk("stall_id", rsp_id, s_id);
         chk("stall_ovf", rsp_ovf, s_ovf);
         chk("stall_req_ready", req_ready, 4'b0000);
      end
      // Release: drain and accept requester 2 in the same cycle
      cycle(4'b1111, 16'h4321, 1'b1);
      chk("release_id", rsp_id, 2'd2);
      chk("release_valid", rsp_valid, 1'b1);

      // Reset while FULL and stalled
      cycle(4'b1111, 16'h4321, 1'b0);
      rsp_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", rsp_valid, 1'b0);
      chk("async_rst_ready", req_ready, 4'b0000);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cycle(4'b1111, 16'hABCD, 1'b1);
      chk("post_rst_id", rsp_id, 2'd0);

      // Randomized traffic; pending requests keep their operand
      pv = '0;
      pd = '0;
      last_acc = 0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (!(pv[i] && !(last_acc != 0 && last_g == i))) begin
               pv[i] = ($urandom_range(0, 3) != 0);
               pd[i*W +: W] = W'($urandom);
            end
         end
         rr = ($urandom_range(0, 3) != 0);
         cycle(pv, pd, rr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
